// File: rtl/wb_regfile.sv
// Write-back source select, 32 x 32-bit architectural register file and commit counter.
// Define WB_BYPASS_EN to make a same-cycle write visible on the ID read ports.
module wb_regfile #(
  parameter int NREG  = 32,
  parameter int CNT_W = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [1:0]       MemtoReg_wb_i,
  input  logic             RegWrite_wb_i,
  input  logic [31:0]      NPC_wb_i,
  input  logic [31:0]      MD_wb_i,
  input  logic [31:0]      ALUOut_wb_i,
  input  logic [31:0]      EXT_wb_i,
  input  logic [31:0]      RD_wb_i,
  input  logic [4:0]       RS_id_i,
  input  logic [4:0]       RT_id_i,
  output logic [31:0]      RD1_id_o,
  output logic [31:0]      RD2_id_o,
  output logic [31:0]      WD_wb_o,
  output logic             WE_wb_o,
  output logic [4:0]       WA_wb_o,
  output logic [CNT_W-1:0] wb_count_o
);

  logic [31:0]      rf_q [NREG];
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [31:0]      wd_d;
  logic             we_d;
  logic [31:0]      rd1_d, rd2_d;
  logic             unused_rd_hi;

  // Upper destination bits carry no meaning in a 32-entry file.
  assign unused_rd_hi = ^RD_wb_i[31:5];

  assign WA_wb_o = RD_wb_i[4:0];

  always_comb begin
    wd_d = ALUOut_wb_i;
    case (MemtoReg_wb_i)
      2'b00:   wd_d = ALUOut_wb_i;
      2'b01:   wd_d = MD_wb_i;
      2'b10:   wd_d = NPC_wb_i;
      default: wd_d = EXT_wb_i;
    endcase
  end

  assign we_d    = RegWrite_wb_i & (RD_wb_i[4:0] != 5'd0) & rst_n;
  assign WD_wb_o = wd_d;
  assign WE_wb_o = we_d;
  assign cnt_d   = cnt_q + CNT_W'(1);

  always_comb begin
    rd1_d = (RS_id_i == 5'd0) ? 32'h0 : rf_q[RS_id_i];
    rd2_d = (RT_id_i == 5'd0) ? 32'h0 : rf_q[RT_id_i];
`ifdef WB_BYPASS_EN
    // we_d already excludes register 0, so the zero-read rule holds here.
    if (we_d && (RS_id_i == WA_wb_o)) rd1_d = wd_d;
    if (we_d && (RT_id_i == WA_wb_o)) rd2_d = wd_d;
`endif
  end

  assign RD1_id_o   = rd1_d;
  assign RD2_id_o   = rd2_d;
  assign wb_count_o = cnt_q;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      for (int i = 0; i < NREG; i++) rf_q[i] <= 32'h0;
      cnt_q <= '0;
    end else if (we_d) begin
      rf_q[WA_wb_o] <= wd_d;
      cnt_q         <= cnt_d;
    end
  end

endmodule

// File: doc/wb_regfile.md
# wb_regfile

Write-back stage and architectural register file of the five-stage pipeline. Consumes the fields held in the MEM/WB pipeline register and selects the write-back value. Commits that value into a 32 x 32-bit register file on the clock edge and serves the two combinational read ports used by the ID stage. Also exports the selected write-back value for EX-stage forwarding, plus a committed-write counter for the testbench.

## Interface
- `NREG`, 32: number of architectural registers; must be 32, address width is fixed at 5.
- `CNT_W`, 32: width of the committed-write counter.

- `clk` in 1: rising-edge clock.
- `rst_n` in 1: reset; synchronous and active-low.
- `MemtoReg_wb_i` in 2: write-back source select.
- `RegWrite_wb_i` in 1: write request.
- `NPC_wb_i` in 32: link value, PC+4 (JAL/JALR).
- `MD_wb_i` in 32: load data.
- `ALUOut_wb_i` in 32: ALU result.
- `EXT_wb_i` in 32: extended immediate (LUI).
- `RD_wb_i` in 32: destination register number; only bits [4:0] are used.
- `RS_id_i` in 5: read address, port 1.
- `RT_id_i` in 5: read address, port 2.
- `RD1_id_o` out 32: read data, port 1.
- `RD2_id_o` out 32: read data, port 2.
- `WD_wb_o` out 32: selected write-back data.
- `WE_wb_o` out 1: effective write enable.
- `WA_wb_o` out 5: effective write address, equal to `RD_wb_i[4:0]`.
- `wb_count_o` out `CNT_W`: committed-write count.

## Operation
- Source select, combinational:
  - 2'b00 selects ALUOut.
  - 2'b01 selects MD.
  - 2'b10 selects NPC.
  - 2'b11 selects EXT.
  - The result drives `WD_wb_o`.
- Effective enable: `WE_wb_o` = `RegWrite_wb_i` & (`RD_wb_i[4:0]` != 0) & `rst_n`.
- Register 0 is hard-wired zero.
  - Writes to it are discarded and not counted.
  - Reads of it always return 32'h0.
- Commit: at posedge `clk`, when `WE_wb_o` = 1, `rf[WA_wb_o]` <= `WD_wb_o` and `wb_count_o` increments by 1.
- Read ports are combinational: `RD1_id_o` = `rf[RS_id_i]` and `RD2_id_o` = `rf[RT_id_i]`, modified by the bypass rule in Configuration.
- Bits `RD_wb_i[31:5]` are ignored. No error is flagged for nonzero upper bits.
- A bubble (all MEM/WB fields zero) is a no-op: `RegWrite` = 0, so nothing is written and nothing is counted.

## Timing
- Reset: at posedge `clk` with `rst_n` = 0:
  - all 32 registers go to 32'h0;
  - `wb_count_o` goes to 0;
  - any simultaneous write request is dropped.
- During reset, `WE_wb_o` is 0, while `WD_wb_o` and `WA_wb_o` still track their inputs combinationally.
- Reset asserted mid-stream: the instruction presented on that edge does not commit. The first commit after release happens on the first edge with `rst_n` = 1.
- Write latency: the value is visible at `rf[]` one edge after presentation. With bypass enabled, it is also visible combinationally in the same cycle.
- Both read ports may address the same register, and either may match `WA_wb_o`. Each port resolves independently.
- Counter wrap: 2^`CNT_W`-1 plus one commit gives 0, with no sticky flag.
- One write per cycle. There is no back-pressure; the stage always accepts its input.

## Configuration
- `WB_BYPASS_EN` defined: internal write-through is enabled.
  - Condition: a read port address equals `WA_wb_o` and `WE_wb_o` = 1.
  - Effect: that port returns `WD_wb_o` in the same cycle. This covers the WB to ID hazard without a stall.
  - A read of register 0 still returns 0.
- `WB_BYPASS_EN` undefined: read ports return the stored `rf[]` only.
  - A same-cycle write is visible from the next cycle.
  - The hazard unit must stall one extra cycle for this case.

## Test plan
- Reset: hold `rst_n` = 0 for 2 edges with `RegWrite` = 1, `RD` = 5, `ALUOut` = 32'h1234.
  - After release: `rf[5]` = 0 and `wb_count_o` = 0.
  - `WE_wb_o` = 0 throughout the reset edges.
- Source select: with `RD` = 8, drive `MemtoReg` 00/01/10/11 on four consecutive edges, with ALUOut = 32'hA, MD = 32'hB, NPC = 32'hC, EXT = 32'hD.
  - `WD_wb_o` shows A, B, C, D in turn.
  - After the last edge: `RD1_id_o` (RS = 8) = 32'hD and `wb_count_o` = 4.
- Register 0: `RegWrite` = 1, `RD` = 32'h0, ALUOut = 32'hFFFF_FFFF.
  - `WE_wb_o` = 0.
  - `RD1_id_o` (RS = 0) = 0.
  - Counter unchanged.
- Upper-bit masking: `RD` = 32'hFFFF_FFE3, `RegWrite` = 1, ALUOut = 32'h55.
  - `WA_wb_o` = 3.
  - `rf[3]` = 32'h55 after the edge.
- Bypass: `rf[7]` = 32'h11, then present a write of 32'h22 to register 7 with RS = RT = 7 in the same cycle.
  - With `WB_BYPASS_EN` defined: both read ports show 32'h22 before the edge.
  - With it undefined: both show 32'h11 before the edge and 32'h22 after it.
- Counter wrap: with `CNT_W` = 4, perform 17 valid writes; `wb_count_o` = 1.
